// File: rtl/cnt_rr_pkg.sv
// cnt_rr_pkg: shared types and helpers for the round-robin interval-timer
// scheduler and its picker.
//   state_e  : two-state FSM encoding (IDLE=0, RUN=1)
//   N_DEF    : default requester count
//   W_DEF    : default counter / duration width
//   onehot() : index -> one-hot vector (up to N_MAX requesters)
package cnt_rr_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 4;
  localparam int N_MAX = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Callers truncate the result to their own requester count.
  function automatic logic [N_MAX-1:0] onehot(input logic [2:0] idx);
    logic [N_MAX-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/cnt_rr_pick.sv
// cnt_rr_pick: combinational rotating-priority picker.
//   req : per-requester request bits
//   ptr : index holding highest priority this round
//   any : at least one request is set
//   sel : first set request scanning ptr, ptr+1, ... mod N
module cnt_rr_pick
  import cnt_rr_pkg::*;
#(
  parameter  int N  = N_DEF,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] sel
);

  // Walk offsets from farthest to nearest so the nearest set bit to ptr
  // is the last one written and therefore wins.
  always_comb begin
    any = 1'b0;
    sel = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[PW'((int'(ptr) + k) % N)]) begin
        any = 1'b1;
        sel = PW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/cnt_rr_sched.sv
// cnt_rr_sched: shares one W-bit up-counter between N requesters in
// round-robin order. The granted requester holds the counter for its
// sampled duration L (0 means 2^W cycles) and then gets a one-cycle done.
//   clk  : clock, rising edge
//   re   : synchronous active-high reset
//   req  : per-requester request level
//   dur  : flattened durations, dur[i*W +: W] for requester i
//   gnt  : one-hot grant (registered), zero when idle
//   done : one-cycle completion pulse (registered)
//   cnt  : current counter value (registered)
//   busy : high while a grant is active
module cnt_rr_sched
  import cnt_rr_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           re,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] dur,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic [W-1:0]   cnt,
  output logic           busy
);

  localparam int PW = $clog2(N);

  state_e        state_q;
  logic [N-1:0]  gnt_q, done_q;
  logic [W-1:0]  cnt_q, len_q;
  logic [PW-1:0] ptr_q, sel_q;

  logic          pick_any;
  logic [PW-1:0] pick_sel;
  logic [W-1:0]  len_d;
  logic [N-1:0]  gnt_d;
  logic [PW-1:0] ptr_d;
  logic          term;

  cnt_rr_pick #(.N(N)) u_pick (
    .req(req),
    .ptr(ptr_q),
    .any(pick_any),
    .sel(pick_sel)
  );

  assign len_d = dur[pick_sel*W +: W];
  assign gnt_d = N'(onehot(3'(pick_sel)));

  // Served requester drops to lowest priority next round.
  assign ptr_d = (sel_q == PW'(N - 1)) ? '0 : sel_q + PW'(1);

  // len-1 in W-bit arithmetic: len==0 terminates at all-ones, i.e. 2^W cycles.
  assign term = (cnt_q == len_q - W'(1));

  always_ff @(posedge clk) begin
    if (re) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ptr_q   <= '0;
      sel_q   <= '0;
    end else begin
      done_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            gnt_q   <= gnt_d;
            len_q   <= len_d;
            sel_q   <= pick_sel;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          // Abort wins over terminal: a withdrawn request never sees done.
          if (!req[sel_q]) begin
            gnt_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end else if (term) begin
            gnt_q   <= '0;
            done_q  <= gnt_q;
            cnt_q   <= '0;
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign cnt  = cnt_q;
  assign busy = (state_q == RUN);

  a_gnt_oh: assert property (@(posedge clk) disable iff (re) $onehot0(gnt));
  a_done_oh: assert property (@(posedge clk) disable iff (re) $onehot0(done));
  a_done_gnt: assert property (@(posedge clk) disable iff (re) (done & gnt) == '0);
  a_idle_cnt: assert property (@(posedge clk) disable iff (re) !busy |-> cnt == '0);

endmodule

// File: tb/tb_cnt_rr_sched.sv
module tb_cnt_rr_sched;

  localparam int N = 4;
  localparam int W = 4;

  typedef struct {
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic [W-1:0] cnt;
    logic         busy;
  } exp_t;

  logic           clk = 1'b0;
  logic           re;
  logic [N-1:0]   req;
  logic [N*W-1:0] dur;
  logic [N-1:0]   gnt, done;
  logic [W-1:0]   cnt;
  logic           busy;

  int checks = 0;
  int errors = 0;

  exp_t sb[$];

  // Reference model: owner index, elapsed cycles, full length in cycles.
  int m_owner = -1;
  int m_el    = 0;
  int m_len   = 0;
  int m_ptr   = 0;
  logic [N-1:0] m_done = '0;

  cnt_rr_sched #(.N(N), .W(W)) dut (
    .clk(clk), .re(re), .req(req), .dur(dur),
    .gnt(gnt), .done(done), .cnt(cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_dur(input int i, input logic [W-1:0] v);
    dur[i*W +: W] = v;
  endtask

  function automatic logic req_bit(input int j);
    logic [1:0] ix;
    ix = j[1:0];
    return req[ix];
  endfunction

  task automatic model_step();
    m_done = '0;
    if (re) begin
      m_owner = -1;
      m_el    = 0;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (m_owner < 0 && req_bit(j)) begin
          m_owner = j;
          m_el    = 0;
          m_len   = (dur[j*W +: W] == '0) ? (1 << W) : int'(dur[j*W +: W]);
        end
      end
    end else if (!req_bit(m_owner)) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_el    = 0;
    end else if (m_el + 1 == m_len) begin
      m_done  = N'(1 << m_owner);
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_el    = 0;
    end else begin
      m_el++;
    end
  endtask

  // One clock: model predicts at the edge, DUT is checked on the falling edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    model_step();
    e.gnt  = (m_owner < 0) ? '0 : N'(1 << m_owner);
    e.done = m_done;
    e.cnt  = W'(m_el);
    e.busy = (m_owner >= 0);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk("gnt",  32'(gnt),  32'(e.gnt));
    chk("done", 32'(done), 32'(e.done));
    chk("cnt",  32'(cnt),  32'(e.cnt));
    chk("busy", 32'(busy), 32'(e.busy));
  endtask

  initial begin
    logic [N-1:0] order [5];
    logic [N-1:0] prev;
    int           ng;
    int           hi;

    re  = 1'b1;
    req = 4'b1111;
    dur = '0;
    for (int i = 0; i < N; i++) set_dur(i, 4'd1);
    @(negedge clk);

    // 1: reset with everything requesting, then first grant goes to 0
    tick();
    tick();
    re = 1'b0;
    tick();
    chk("t1_first_gnt", 32'(gnt), 32'h1);
    req = '0;
    tick();
    tick();

    // 2: single request, duration 3
    req = 4'b0100;
    set_dur(2, 4'd3);
    tick();
    tick();
    tick();
    chk("t2_cnt2", 32'(cnt), 32'd2);
    tick();
    chk("t2_done", 32'(done), 32'h4);
    req = '0;
    tick();
    tick();

    // 3: rotation with all four requesting, duration 2
    re = 1'b1;
    tick();
    re  = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < N; i++) set_dur(i, 4'd2);
    prev = '0;
    ng   = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (gnt != '0 && prev == '0 && ng < 5) begin
        order[ng] = gnt;
        ng++;
      end
      prev = gnt;
    end
    chk("t3_ngrants", 32'(ng), 32'd5);
    chk("t3_order0", 32'(order[0]), 32'h1);
    chk("t3_order1", 32'(order[1]), 32'h2);
    chk("t3_order2", 32'(order[2]), 32'h4);
    chk("t3_order3", 32'(order[3]), 32'h8);
    chk("t3_order4", 32'(order[4]), 32'h1);
    req = '0;
    tick();
    tick();

    // 4: duration 0 means a full 16-cycle wrap
    req = 4'b0001;
    set_dur(0, 4'd0);
    hi = 0;
    for (int c = 0; c < 17; c++) begin
      tick();
      if (gnt != '0) hi++;
    end
    chk("t4_gnt_cycles", 32'(hi), 32'd16);
    chk("t4_done", 32'(done), 32'h1);
    req = '0;
    tick();
    tick();

    // 5: abort at cnt=2, then pointer past requester 1 favours 0
    req = 4'b0010;
    set_dur(1, 4'd5);
    tick();
    tick();
    tick();
    chk("t5_cnt2", 32'(cnt), 32'd2);
    req = '0;
    tick();
    chk("t5_abort_gnt", 32'(gnt), 32'h0);
    chk("t5_abort_done", 32'(done), 32'h0);
    req = 4'b0011;
    tick();
    chk("t5_regrant", 32'(gnt), 32'h1);
    req = '0;
    tick();
    tick();

    // 6: reset during a grant to requester 3
    req = 4'b1000;
    set_dur(3, 4'd6);
    for (int c = 0; c < 20 && gnt != 4'b1000; c++) tick();
    chk("t6_gnt3", 32'(gnt), 32'h8);
    for (int c = 0; c < 20 && cnt != 4'd4; c++) tick();
    chk("t6_cnt4", 32'(cnt), 32'd4);
    re = 1'b1;
    tick();
    chk("t6_rst_gnt", 32'(gnt), 32'h0);
    chk("t6_rst_done", 32'(done), 32'h0);
    re  = 1'b0;
    req = 4'b1001;
    tick();
    chk("t6_regrant", 32'(gnt), 32'h1);
    req = '0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnt_rr_sched.md
Name: cnt_rr_sched

Overview:
- Round-robin scheduler that shares one W-bit synchronous up-counter (interval timer) between N requesters.
- Each requester presents a requested duration. The block grants the counter to one requester at a time, counts out the duration, then pulses done to that requester.
- Sits between client blocks needing timed windows and the shared counter datapath. Owns the counter register internally.

Parameters:
- N, 4, number of requesters (2..8)
- W, 4, counter / duration width in bits

Ports:
- clk  input  1  system clock, all logic on rising edge
- re  input  1  reset; synchronous, active-high
- req  input  N  per-requester request level; bit i = requester i
- dur  input  N*W  flattened durations; dur[i*W +: W] belongs to requester i
- gnt  output  N  one-hot grant, registered; all-zero when idle
- done  output  N  one-cycle completion pulse to the granted requester, registered
- cnt  output  W  current counter value, registered
- busy  output  1  high while in RUN (equals OR of gnt)

Behaviour:
- Reset (re=1 at a rising edge) sets the following on the next edge. This also applies mid-RUN: an active grant is dropped with no done pulse.
  - gnt=0, done=0, cnt=0, busy=0
  - state=IDLE
  - pointer ptr=0
- States: IDLE, RUN. Two-state FSM with a registered state.
- IDLE:
  - If req==0: stay in IDLE; cnt, gnt and done stay 0 (done is 0 after its pulse).
  - If req!=0: select sel = first set bit of req, scanning ptr, ptr+1, ... mod N.
  - On the next edge: gnt<=onehot(sel), len<=dur[sel], cnt<=0, state<=RUN.
  - req and dur are sampled only in IDLE. dur changes during RUN are ignored.
- Duration rule:
  - Grant lasts exactly L cycles, where L = len, except len==0 gives L = 2^W.
  - Terminal condition is cnt == len-1 in W-bit wrap arithmetic. For len==0 that is cnt == all-ones, so the full wrap path is exercised.
- RUN, every edge:
  - Abort: if req[sel]==0, then gnt<=0, cnt<=0, done stays 0, ptr<=(sel+1) mod N, state<=IDLE. Abort takes priority over the terminal condition.
  - Terminal: else if the terminal condition holds, then gnt<=0, done[sel]<=1 for one cycle, cnt<=0, ptr<=(sel+1) mod N, state<=IDLE.
  - Otherwise: cnt<=cnt+1 (W-bit wrap), gnt held.
- Timing:
  - Latency from req seen in IDLE to gnt high: 1 cycle.
  - The done pulse coincides with the first IDLE cycle. A new grant can start on the following edge.
  - Back-to-back service period is therefore L+1 cycles.
- Fairness: the requester just served (completed or aborted) has lowest priority in the next arbitration. Under continuous requests from all N, grants rotate 0,1,...,N-1,0.
- Invariants (checked by assertions):
  - gnt is one-hot or zero.
  - done is one-hot or zero, and is never high together with gnt.
  - cnt==0 whenever busy==0.

Decomposition:
- Shared package cnt_rr_pkg:
  - state type/encoding (IDLE=0, RUN=1)
  - default N and W constants
  - function onehot(idx)
- One natural sub-module: cnt_rr_pick. Purely combinational rotating-priority picker.
  - Inputs: req[N], ptr.
  - Outputs: any, sel index.
  - Reusable by other arbiters in the codebase.
- FSM, counter and len/ptr registers stay in cnt_rr_sched.

Test Plan:
1. Reset behaviour: re=1 for 2 cycles with req=4'b1111 -> gnt=0, done=0, cnt=0, busy=0 throughout. First grant after re drops is gnt=4'b0001.
2. Single request, dur=3: req=4'b0100, dur[2]=3 -> gnt=4'b0100 for exactly 3 cycles with cnt 0,1,2. Then done=4'b0100 for 1 cycle, cnt=0, busy=0.
3. Round-robin rotation: req=4'b1111 held, all dur=2 -> grant order 0,1,2,3,0. Each grant is 2 cycles and each done pulse is followed by the next gnt one cycle later.
4. Full wrap: req=4'b0001, dur[0]=0 -> gnt high 16 cycles, cnt 0..15, done[0] pulses after cnt=15. cnt does not continue past 15.
5. Abort: req=4'b0010, dur[1]=5, drop req[1] when cnt=2 -> gnt=0 on the next edge, no done pulse. A subsequent req=4'b0011 grants requester 0 first (ptr advanced to 2, wraps to 0).
6. Reset mid-RUN: grant to requester 3 with dur=6, assert re at cnt=4 -> next edge gnt=0, cnt=0, no done. After release, req=4'b1001 grants requester 0 (ptr back to 0).
